// File: rtl/shift_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sched_pkg
//  Description : Shared types and constants for the barrel shifter scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Internal register stages inside the shared barrel shifter.
    localparam int SH_PIPE_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter; a tie goes to the requester
//                that did not win last time.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/barrel_shift_sched.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_sched
//  Description : Arbitrates two requesters onto one pipelined barrel shifter
//                and returns the result through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_sched
    import shift_sched_pkg::*;
#(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_i,
    input  logic [2*SWR-1:0] data_i,
    input  logic [1:0]       dir_i,
    input  logic [2*EWR-1:0] amt_i,
    input  logic [1:0]       fill_i,
    output logic [1:0]       gnt_o,
    output logic [SWR-1:0]   sh_data_o,
    output logic             sh_dir_o,
    output logic [EWR-1:0]   sh_amt_o,
    output logic             sh_fill_o,
    output logic             sh_load_o,
    input  logic [SWR-1:0]   sh_data_i,
    output logic [SWR-1:0]   res_data_o,
    output logic             res_id_o,
    output logic             res_valid_o,
    input  logic             res_ready_i
);

    localparam logic [1:0] WAIT_LAST = 2'(SH_PIPE_LAT - 1);

    state_t           state_q,     state_d;
    logic [SWR-1:0]   sh_data_q,   sh_data_d;
    logic             sh_dir_q,    sh_dir_d;
    logic [EWR-1:0]   sh_amt_q,    sh_amt_d;
    logic             sh_fill_q,   sh_fill_d;
    logic             id_q,        id_d;
    logic [1:0]       wait_cnt_q,  wait_cnt_d;
    logic [SWR-1:0]   res_data_q,  res_data_d;
    logic             res_id_q,    res_id_d;
    logic             res_valid_q, res_valid_d;

    logic             arb_en;
    logic [1:0]       gnt;
    logic             win;
    logic [SWR-1:0]   win_data;
    logic             win_dir;
    logic [EWR-1:0]   win_amt;
    logic             win_fill;

    // Grants are suppressed while reset is asserted so outputs read as 0.
    assign arb_en = rst && (state_q == IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (arb_en),
        .req_i (req_i),
        .gnt_o (gnt)
    );

    assign win      = gnt[1];
    assign win_data = win ? data_i[2*SWR-1:SWR] : data_i[SWR-1:0];
    assign win_dir  = win ? dir_i[1]            : dir_i[0];
    assign win_amt  = win ? amt_i[2*EWR-1:EWR]  : amt_i[EWR-1:0];
    assign win_fill = win ? fill_i[1]           : fill_i[0];

    always_comb begin
        state_d     = state_q;
        sh_data_d   = sh_data_q;
        sh_dir_d    = sh_dir_q;
        sh_amt_d    = sh_amt_q;
        sh_fill_d   = sh_fill_q;
        id_d        = id_q;
        wait_cnt_d  = wait_cnt_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    id_d = win;
                    if (win_amt == '0) begin
                        // Zero shift skips the shifter; sh_* keep their old values.
                        res_data_d  = win_data;
                        res_id_d    = win;
                        res_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        sh_data_d = win_data;
                        sh_dir_d  = win_dir;
                        sh_amt_d  = win_amt;
                        sh_fill_d = win_fill;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = 2'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    res_data_d  = sh_data_i;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            HOLD: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sh_data_q   <= '0;
            sh_dir_q    <= 1'b0;
            sh_amt_q    <= '0;
            sh_fill_q   <= 1'b0;
            id_q        <= 1'b0;
            wait_cnt_q  <= 2'd0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_data_q   <= sh_data_d;
            sh_dir_q    <= sh_dir_d;
            sh_amt_q    <= sh_amt_d;
            sh_fill_q   <= sh_fill_d;
            id_q        <= id_d;
            wait_cnt_q  <= wait_cnt_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign gnt_o       = gnt;
    assign sh_data_o   = sh_data_q;
    assign sh_dir_o    = sh_dir_q;
    assign sh_amt_o    = sh_amt_q;
    assign sh_fill_o   = sh_fill_q;
    assign sh_load_o   = (state_q == ISSUE);
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;
    assign res_valid_o = res_valid_q;

endmodule
`default_nettype wire
